ir_regfile_mp: RTL and testbench
================================

Name: ir_regfile_mp

Overview:
Parametrised multi-read-port instruction register file with a built-in initialisation sequencer.
- After reset, the sequencer fills every entry from instruction memory through a req/ack handshake (states LINIT, LREAD_MEM, LWORK).
- In LWORK it serves one write port and RD_PORTS independent registered read ports.
- Sits between the instruction-memory interface and the decode stage.

Parameters:
DATA_W, 16, entry width in bits
ADDR_W, 4, entry address width; DEPTH = 2**ADDR_W
RD_PORTS, 2, number of read ports (1..4)
MEM_AW, 16, instruction-memory address width
INIT_BASE, 0, memory address loaded into entry 0

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-high (1 = reset asserted)
reinit  input  1  pulse in LWORK restarts the init sequence
mem_req  output  1  memory read request
mem_addr  output  MEM_AW  memory read address
mem_ack  input  1  memory data valid, one-cycle pulse per request
mem_rdata  input  DATA_W  memory read data, valid with mem_ack
init_done  output  1  high while in LWORK
wr_en  input  1  write strobe
wr_addr  input  ADDR_W  write address
wr_data  input  DATA_W  write data
wr_ready  output  1  write accepted this cycle (= init_done)
rd_en  input  RD_PORTS  per-port read strobe
rd_addr  input  RD_PORTS*ADDR_W  packed read addresses, port p at [p*ADDR_W +: ADDR_W]
rd_data  output  RD_PORTS*DATA_W  packed registered read data
rd_valid  output  RD_PORTS  per-port data valid

Behaviour:
- Reset (asynchronous, rst_n=1) forces:
  - state=LINIT, load counter=0
  - mem_req=0, mem_addr=0, init_done=0, rd_data=0, rd_valid=0
  - Storage array is not reset.
- LINIT: one cycle. Counter is cleared, then LREAD_MEM is entered.
- LREAD_MEM:
  - mem_req=1, mem_addr=INIT_BASE+counter, zero-extended or truncated to MEM_AW.
  - mem_req stays high until mem_ack.
  - On mem_ack: mem_rdata is written to entry[counter].
    - counter==DEPTH-1: go to LWORK; mem_req=0 next cycle.
    - Otherwise: counter+1; mem_addr advances next cycle; mem_req stays 1.
  - mem_ack while not in LREAD_MEM is ignored.
- LWORK:
  - init_done=1 and wr_ready=1.
  - wr_en writes wr_data to entry[wr_addr] at the clock edge.
- Read port p, latency 1:
  - rd_en[p] in cycle N with init_done=1 gives rd_data[p] = entry[rd_addr[p]] and rd_valid[p]=1 in cycle N+1.
  - rd_en[p]=0: rd_valid[p]=0 next cycle; rd_data[p] holds its last value.
- Read/write same address, same cycle: the read returns the NEW wr_data (write-through bypass).
- Several ports may read the same address in the same cycle; all receive identical data.
- During LINIT/LREAD_MEM:
  - wr_en is ignored (wr_ready=0).
  - rd_en is ignored; rd_valid=0.
- reinit in LWORK: go to LINIT next cycle and clear init_done.
  - A write in the same cycle as reinit is still performed.
  - reinit in other states is ignored.
- Reset mid-LREAD_MEM: mem_req drops immediately (async). After release the sequence restarts at entry 0; entries already loaded are not trusted.
- Counter width is ADDR_W. No wrap occurs, because LWORK is entered at DEPTH-1.

Optional Feature:
Macro IR_REGFILE_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed on write, both memory load and wr_en.
  - Added output rd_perr, width RD_PORTS, registered alongside rd_valid. It is 1 when recomputed parity of the read data mismatches the stored bit.
  - Reset value 0.
  - A bypassed read never flags an error.
- Undefined: no parity storage and no rd_perr port.

Decomposition:
- Shared package/define file (define.v): state encodings LINIT=2'd0, LREAD_MEM=2'd1, LWORK=2'd2, plus default width constants IRR_WIDTH and IR_ADDR_WIDTH that the parameters default from.
- One sub-module, ir_regfile_rdport: a single registered read port with write-bypass compare, instantiated RD_PORTS times via generate.

Test Plan:
- Init fill: DEPTH=16, INIT_BASE=0x100, memory returns 0xA000+addr with 2-cycle ack latency -> mem_addr steps 0x100..0x10F, init_done rises one cycle after 16th ack, entry[5] reads 0xA005.
- Back-to-back ack (ack every cycle) -> 16 entries loaded in 16 cycles after LINIT, no dropped or duplicated address.
- Bypass: in LWORK, write entry 3=0x1234 while port0 and port1 both read 3 -> both rd_data=0x1234, rd_valid=2'b11 next cycle.
- Blocked access during init: wr_en=1 addr 2 data 0xFFFF and rd_en=1 during LREAD_MEM -> wr_ready=0, rd_valid=0, entry 2 later holds the memory value.
- Reset mid-load: assert rst_n=1 after 7 acks -> mem_req=0 in the same cycle; after release mem_addr restarts at 0x100.
- Reinit plus parity (IR_REGFILE_PARITY_EN): reinit pulse in LWORK -> init_done=0 next cycle, reload completes; force-flip a stored bit, then read -> rd_perr[p]=1 with rd_valid[p]=1.

Source files
------------

// File: rtl/ir_regfile_mp_pkg.sv
// Shared types and default widths for the instruction register file.
//   state_e        : init sequencer states (LINIT, LREAD_MEM, LWORK)
//   IRR_WIDTH      : default entry width
//   IR_ADDR_WIDTH  : default entry address width
//   IR_MEM_AW      : default instruction-memory address width
//   IR_RD_PORTS    : default number of read ports
package ir_regfile_mp_pkg;

  typedef enum logic [1:0] {
    LINIT     = 2'd0,
    LREAD_MEM = 2'd1,
    LWORK     = 2'd2
  } state_e;

  localparam int unsigned IRR_WIDTH     = 16;
  localparam int unsigned IR_ADDR_WIDTH = 4;
  localparam int unsigned IR_MEM_AW     = 16;
  localparam int unsigned IR_RD_PORTS   = 2;

endpackage

// File: rtl/ir_regfile_mp_if.sv
// Bus bundle between instruction memory, the register file and the decode stage.
//   memory side : mem_req/mem_addr out, mem_ack/mem_rdata in
//   control     : reinit in, init_done out
//   write port  : wr_en/wr_addr/wr_data in, wr_ready out
//   read ports  : rd_en/rd_addr in, rd_data/rd_valid out (packed per port)
//   rd_perr     : per-port parity error, only with IR_REGFILE_PARITY_EN
// Modport slave is the register file view, master is the surrounding logic.
interface ir_regfile_mp_if
  import ir_regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = IRR_WIDTH,
  parameter int unsigned ADDR_W   = IR_ADDR_WIDTH,
  parameter int unsigned RD_PORTS = IR_RD_PORTS,
  parameter int unsigned MEM_AW   = IR_MEM_AW
);

  logic                         reinit;
  logic                         mem_req;
  logic [MEM_AW-1:0]            mem_addr;
  logic                         mem_ack;
  logic [DATA_W-1:0]            mem_rdata;
  logic                         init_done;
  logic                         wr_en;
  logic [ADDR_W-1:0]            wr_addr;
  logic [DATA_W-1:0]            wr_data;
  logic                         wr_ready;
  logic [RD_PORTS-1:0]          rd_en;
  logic [RD_PORTS*ADDR_W-1:0]   rd_addr;
  logic [RD_PORTS*DATA_W-1:0]   rd_data;
  logic [RD_PORTS-1:0]          rd_valid;
`ifdef IR_REGFILE_PARITY_EN
  logic [RD_PORTS-1:0]          rd_perr;
`endif

  modport slave (
    input  reinit, mem_ack, mem_rdata, wr_en, wr_addr, wr_data, rd_en, rd_addr,
`ifdef IR_REGFILE_PARITY_EN
    output rd_perr,
`endif
    output mem_req, mem_addr, init_done, wr_ready, rd_data, rd_valid
  );

  modport master (
    output reinit, mem_ack, mem_rdata, wr_en, wr_addr, wr_data, rd_en, rd_addr,
`ifdef IR_REGFILE_PARITY_EN
    input  rd_perr,
`endif
    input  mem_req, mem_addr, init_done, wr_ready, rd_data, rd_valid
  );

endinterface

// File: rtl/ir_regfile_rdport.sv
// One registered read port with write-through bypass.
//   en       : read strobe already qualified with init_done
//   addr     : read address; word/par are the stored entry at addr
//   wr_*     : qualified write port, used for the same-address bypass
//   data     : registered read data, holds when en is low
//   valid    : registered en
//   perr     : registered parity mismatch (IR_REGFILE_PARITY_EN only)
module ir_regfile_rdport
  import ir_regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W = IRR_WIDTH,
  parameter int unsigned ADDR_W = IR_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] word,
`ifdef IR_REGFILE_PARITY_EN
  input  logic              par,
`endif
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data,
  output logic              valid
`ifdef IR_REGFILE_PARITY_EN
  ,
  output logic              perr
`endif
);

  // A write landing on the address being read wins over the stored word.
  logic hit;
  assign hit = wr_en && (wr_addr == addr);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      data  <= '0;
      valid <= 1'b0;
`ifdef IR_REGFILE_PARITY_EN
      perr  <= 1'b0;
`endif
    end else begin
      valid <= en;
      if (en) data <= hit ? wr_data : word;
`ifdef IR_REGFILE_PARITY_EN
      // Bypassed data never came from storage, so it cannot be corrupt.
      perr  <= en && !hit && ((^word) != par);
`endif
    end
  end

endmodule

// File: rtl/ir_regfile_mp.sv
// Multi-read-port instruction register file with an init sequencer that
// fills every entry from instruction memory after reset or reinit.
//   clk    : clock, rising edge
//   rst_n  : asynchronous reset, active high
//   bus    : ir_regfile_mp_if.slave (memory, control, write and read ports)
// Optional macro IR_REGFILE_PARITY_EN adds per-entry even parity and rd_perr.
module ir_regfile_mp
  import ir_regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W    = IRR_WIDTH,
  parameter int unsigned ADDR_W    = IR_ADDR_WIDTH,
  parameter int unsigned RD_PORTS  = IR_RD_PORTS,
  parameter int unsigned MEM_AW    = IR_MEM_AW,
  parameter int unsigned INIT_BASE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  ir_regfile_mp_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx, cnt_inc;
  logic              mem_req, mem_req_nx;
  logic [MEM_AW-1:0] mem_addr, mem_addr_nx;
  logic              init_done, init_done_nx;
  logic              load_we;
  logic              wr_we;

  logic [DATA_W-1:0] store [DEPTH];
`ifdef IR_REGFILE_PARITY_EN
  logic              par_store [DEPTH];
`endif

  // Memory address for load slot c: INIT_BASE + c, sized to MEM_AW.
  function automatic logic [MEM_AW-1:0] load_addr(input logic [ADDR_W-1:0] c);
    return MEM_AW'(INIT_BASE + 32'(c));
  endfunction

  assign cnt_inc = cnt + ADDR_W'(1);
  assign wr_we   = bus.wr_en && init_done;

  // Sequencer next-state and registered-output values.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    mem_req_nx   = mem_req;
    mem_addr_nx  = mem_addr;
    init_done_nx = init_done;
    load_we      = 1'b0;
    case (state)
      LINIT: begin
        state_nx     = LREAD_MEM;
        cnt_nx       = '0;
        mem_req_nx   = 1'b1;
        mem_addr_nx  = load_addr('0);
        init_done_nx = 1'b0;
      end
      LREAD_MEM: begin
        if (bus.mem_ack) begin
          load_we = 1'b1;
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state_nx     = LWORK;
            mem_req_nx   = 1'b0;
            init_done_nx = 1'b1;
          end else begin
            cnt_nx      = cnt_inc;
            mem_addr_nx = load_addr(cnt_inc);
          end
        end
      end
      LWORK: begin
        if (bus.reinit) begin
          state_nx     = LINIT;
          mem_req_nx   = 1'b0;
          init_done_nx = 1'b0;
        end
      end
      default: begin
        state_nx     = LINIT;
        mem_req_nx   = 1'b0;
        init_done_nx = 1'b0;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= LINIT;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      mem_req   <= mem_req_nx;
      mem_addr  <= mem_addr_nx;
      init_done <= init_done_nx;
    end
  end

  // Storage; load and user writes never overlap since they live in different states.
  always_ff @(posedge clk) begin
    if (load_we) begin
      store[cnt] <= bus.mem_rdata;
    end else if (wr_we) begin
      store[bus.wr_addr] <= bus.wr_data;
    end
  end

`ifdef IR_REGFILE_PARITY_EN
  always_ff @(posedge clk) begin
    if (load_we) begin
      par_store[cnt] <= ^bus.mem_rdata;
    end else if (wr_we) begin
      par_store[bus.wr_addr] <= ^bus.wr_data;
    end
  end
`endif

  logic [RD_PORTS*DATA_W-1:0] rd_data;
  logic [RD_PORTS-1:0]        rd_valid;
`ifdef IR_REGFILE_PARITY_EN
  logic [RD_PORTS-1:0]        rd_perr;
`endif

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = bus.rd_addr[p*ADDR_W +: ADDR_W];

    ir_regfile_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_port (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (bus.rd_en[p] && init_done),
      .addr    (addr),
      .word    (store[addr]),
`ifdef IR_REGFILE_PARITY_EN
      .par     (par_store[addr]),
`endif
      .wr_en   (wr_we),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .data    (rd_data[p*DATA_W +: DATA_W]),
      .valid   (rd_valid[p])
`ifdef IR_REGFILE_PARITY_EN
      ,
      .perr    (rd_perr[p])
`endif
    );
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_addr  = mem_addr;
  assign bus.init_done = init_done;
  assign bus.wr_ready  = init_done;
  assign bus.rd_data   = rd_data;
  assign bus.rd_valid  = rd_valid;
`ifdef IR_REGFILE_PARITY_EN
  assign bus.rd_perr   = rd_perr;
`endif

endmodule

// File: tb/tb_ir_regfile_mp.sv
// Directed bench for ir_regfile_mp: init fill, blocked access during load,
// reads, bypass, stray ack, reinit with back-to-back acks, reset mid-load,
// and parity checks when IR_REGFILE_PARITY_EN is defined.
module tb_ir_regfile_mp;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned RD_PORTS  = 2;
  localparam int unsigned MEM_AW    = 16;
  localparam int unsigned INIT_BASE = 'h100;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  ir_regfile_mp_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_PORTS(RD_PORTS), .MEM_AW(MEM_AW)
  ) bus ();

  ir_regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_PORTS(RD_PORTS),
    .MEM_AW(MEM_AW), .INIT_BASE(INIT_BASE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory responder: acks a pending request after 'lat' idle negedges.
  int          lat = 2;
  int          wcnt = 0;
  bit          stray = 1'b0;
  logic [15:0] acks[$];
  time         last_ack_t = 0;

  always @(negedge clk) begin
    bus.mem_ack = 1'b0;
    if (stray) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'hDEAD;
    end else if (rst_n || bus.mem_req !== 1'b1) begin
      wcnt = 0;
    end else if (wcnt >= lat) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'hA000 + {8'h00, bus.mem_addr[7:0]};
      acks.push_back(bus.mem_addr);
      last_ack_t = $time;
      wcnt = 0;
    end else begin
      wcnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (bus.init_done !== 1'b1 && cycles < budget) begin
      step();
      cycles++;
    end
    chk("init_done_reached", 64'(bus.init_done), 64'd1);
  endtask

  task automatic check_addrs(input string tag);
    chk({tag, "_ack_count"}, 64'(acks.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_addr"}, 64'(acks[i]), 64'(INIT_BASE + i));
    end
  endtask

  int cyc;

  initial begin
    bus.reinit  = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_en   = '0;
    bus.rd_addr = '0;

    // Reset state.
    step(3);
    chk("rst_mem_req",   64'(bus.mem_req),   64'd0);
    chk("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
    chk("rst_init_done", 64'(bus.init_done), 64'd0);
    chk("rst_wr_ready",  64'(bus.wr_ready),  64'd0);
    chk("rst_rd_valid",  64'(bus.rd_valid),  64'd0);
    chk("rst_rd_data",   64'(bus.rd_data),   64'd0);

    // LINIT lasts one cycle, then the first request goes out.
    rst_n = 1'b0;
    step();
    chk("load_first_req",  64'(bus.mem_req),  64'd1);
    chk("load_first_addr", 64'(bus.mem_addr), 64'h100);

    // Writes and reads during load must be blocked.
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd2;
    bus.wr_data = 16'hFFFF;
    bus.rd_en   = 2'b11;
    bus.rd_addr = {4'd2, 4'd2};
    for (int i = 0; i < 60 && acks.size() < 5; i++) step();
    chk("load_wr_ready", 64'(bus.wr_ready), 64'd0);
    chk("load_rd_valid", 64'(bus.rd_valid), 64'd0);
    bus.wr_en = 1'b0;
    bus.rd_en = 2'b00;

    wait_done(200, cyc);
    chk("done_one_cycle_after_ack", 64'($time - last_ack_t), 64'd6);
    chk("done_mem_req",  64'(bus.mem_req),  64'd0);
    chk("done_wr_ready", 64'(bus.wr_ready), 64'd1);
    check_addrs("fill");

    // Two-port read; entry 2 kept its loaded value.
    bus.rd_addr = {4'd2, 4'd5};
    bus.rd_en   = 2'b11;
    step();
    bus.rd_en = 2'b00;
    chk("rd_valid_both", 64'(bus.rd_valid), 64'h3);
    chk("rd_data_5_2",   64'(bus.rd_data),  64'hA002A005);
    step();
    chk("rd_idle_valid", 64'(bus.rd_valid), 64'h0);
    chk("rd_idle_hold",  64'(bus.rd_data),  64'hA002A005);

    // Write-through bypass on both ports.
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd3;
    bus.wr_data = 16'h1234;
    bus.rd_addr = {4'd3, 4'd3};
    bus.rd_en   = 2'b11;
    step();
    bus.wr_en = 1'b0;
    bus.rd_en = 2'b00;
    chk("bypass_valid", 64'(bus.rd_valid), 64'h3);
    chk("bypass_data",  64'(bus.rd_data),  64'h12341234);

    // Port 1 alone, then port 0 alone reading the written entry.
    bus.rd_addr = {4'd4, 4'd3};
    bus.rd_en   = 2'b10;
    step();
    chk("p1_only_valid", 64'(bus.rd_valid), 64'h2);
    chk("p1_only_data",  64'(bus.rd_data),  64'hA0041234);
    bus.rd_en = 2'b01;
    step();
    bus.rd_en = 2'b00;
    chk("p0_only_valid", 64'(bus.rd_valid), 64'h1);
    chk("p0_written",    64'(bus.rd_data),  64'hA0041234);

    // Bypass on one port, storage read on the other.
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd7;
    bus.wr_data = 16'hBEEF;
    bus.rd_addr = {4'd7, 4'd6};
    bus.rd_en   = 2'b11;
    step();
    bus.wr_en = 1'b0;
    bus.rd_en = 2'b00;
    chk("mixed_data", 64'(bus.rd_data), 64'hBEEFA006);

    // Stray ack in LWORK is ignored.
    stray = 1'b1;
    step();
    stray = 1'b0;
    step();
    bus.rd_addr = {4'd15, 4'd0};
    bus.rd_en   = 2'b11;
    step();
    bus.rd_en = 2'b00;
    chk("stray_ack_data", 64'(bus.rd_data), 64'hA00FA000);
    chk("stray_init_done", 64'(bus.init_done), 64'd1);

    // Reinit with back-to-back acks; a mid-load reinit pulse is ignored.
    acks.delete();
    lat         = 0;
    bus.reinit  = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd9;
    bus.wr_data = 16'h5555;
    step();
    bus.reinit = 1'b0;
    bus.wr_en  = 1'b0;
    chk("reinit_done_low",  64'(bus.init_done), 64'd0);
    chk("reinit_wr_ready",  64'(bus.wr_ready),  64'd0);
    step();
    chk("reinit_req",  64'(bus.mem_req),  64'd1);
    chk("reinit_addr", 64'(bus.mem_addr), 64'h100);
    bus.reinit = 1'b1;
    step();
    bus.reinit = 1'b0;
    step(3);
    wait_done(100, cyc);
    chk("b2b_load_cycles", 64'(cyc), 64'd12);
    check_addrs("b2b");
    bus.rd_addr = {4'd3, 4'd9};
    bus.rd_en   = 2'b11;
    step();
    bus.rd_en = 2'b00;
    chk("reload_data", 64'(bus.rd_data), 64'hA003A009);

    // Reset in the middle of a load.
    acks.delete();
    lat        = 2;
    bus.reinit = 1'b1;
    step();
    bus.reinit = 1'b0;
    for (int i = 0; i < 200 && acks.size() < 7; i++) step();
    chk("midload_acks", 64'(acks.size()), 64'd7);
    chk("midload_req_before", 64'(bus.mem_req), 64'd1);
    rst_n = 1'b1;
    #1;
    chk("midload_req_async", 64'(bus.mem_req),  64'd0);
    chk("midload_addr_rst",  64'(bus.mem_addr), 64'd0);
    step(2);
    acks.delete();
    rst_n = 1'b0;
    step();
    chk("restart_req",  64'(bus.mem_req),  64'd1);
    chk("restart_addr", 64'(bus.mem_addr), 64'h100);
    wait_done(200, cyc);
    check_addrs("restart");
    bus.rd_addr = {4'd12, 4'd5};
    bus.rd_en   = 2'b11;
    step();
    bus.rd_en = 2'b00;
    chk("restart_data", 64'(bus.rd_data), 64'hA00CA005);

`ifdef IR_REGFILE_PARITY_EN
    chk("perr_clean", 64'(bus.rd_perr), 64'h0);
    dut.store[5] = dut.store[5] ^ 16'h0001;
    bus.rd_addr = {4'd12, 4'd5};
    bus.rd_en   = 2'b01;
    step();
    bus.rd_en = 2'b00;
    chk("perr_valid", 64'(bus.rd_valid), 64'h1);
    chk("perr_flag",  64'(bus.rd_perr),  64'h1);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd5;
    bus.wr_data = 16'h0007;
    bus.rd_en   = 2'b01;
    step();
    bus.wr_en = 1'b0;
    bus.rd_en = 2'b00;
    chk("perr_bypass", 64'(bus.rd_perr), 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
